// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - time-multiplexed scan controller for a 4-digit seven-segment display
// Optional digit blinking is compiled in when SEVENSEG_BLINK_EN is defined.
module sevenseg_scan_ctrl #(
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_TICKS     = 1000
`ifdef SEVENSEG_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES    = 64
`endif
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SEVENSEG_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_value,
    input  logic [3:0]  upd_dp,
    input  logic [3:0]  upd_en,
    output logic [15:0] dec_value,
    output logic [3:0]  dec_dp,
    input  logic [7:0]  dec_digits [0:3],
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start
);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } state_t;

    localparam state_t      START      = (BLANK_TICKS == 0) ? S_ON : S_BLANK;
    localparam logic [31:0] ON_LAST    = TICKS_PER_DIGIT - 1;
    localparam logic [31:0] BLANK_LAST = BLANK_TICKS - 1;

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [31:0] cnt, cnt_n;
    logic        run;
    logic        wrap;
    logic        commit;

    logic        pend_full;
    logic [15:0] pend_value;
    logic [3:0]  pend_dp;
    logic [3:0]  pend_en;
    logic [3:0]  shown_en;
    logic [3:0]  en_eff;

    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    assign upd_ready = ~pend_full;
    assign commit    = wrap & pend_full;

    // run holds the FSM in its reset state for the first edge, which opens frame 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run   <= 1'b0;
            state <= START;
            idx   <= 2'd0;
            cnt   <= 32'd0;
        end else begin
            run   <= 1'b1;
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt;
        wrap    = 1'b0;
        if (run) begin
            case (state)
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_n = S_ON;
                        cnt_n   = 32'd0;
                    end else begin
                        cnt_n = cnt + 32'd1;
                    end
                end
                S_ON: begin
                    if (cnt == ON_LAST) begin
                        idx_n   = idx + 2'd1;
                        cnt_n   = 32'd0;
                        state_n = (BLANK_TICKS == 0) ? S_ON : S_BLANK;
                        wrap    = (idx == 2'd3);
                    end else begin
                        cnt_n = cnt + 32'd1;
                    end
                end
                default: state_n = START;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_full  <= 1'b0;
            pend_value <= 16'h0;
            pend_dp    <= 4'h0;
            pend_en    <= 4'h0;
        end else if (upd_valid && upd_ready) begin
            pend_full  <= 1'b1;
            pend_value <= upd_value;
            pend_dp    <= upd_dp;
            pend_en    <= upd_en;
        end else if (commit) begin
            pend_full  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_value <= 16'h0;
            dec_dp    <= 4'h0;
            shown_en  <= 4'h0;
        end else if (commit) begin
            dec_value <= pend_value;
            dec_dp    <= pend_dp;
            shown_en  <= pend_en;
        end
    end

`ifdef SEVENSEG_BLINK_EN
    localparam logic [31:0] BLINK_LAST = BLINK_FRAMES - 1;

    logic        phase, phase_n;
    logic [31:0] fcnt, fcnt_n;

    always_comb begin
        phase_n = phase;
        fcnt_n  = fcnt;
        if (wrap) begin
            if (fcnt == BLINK_LAST) begin
                fcnt_n  = 32'd0;
                phase_n = ~phase;
            end else begin
                fcnt_n = fcnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b1;
            fcnt  <= 32'd0;
        end else begin
            phase <= phase_n;
            fcnt  <= fcnt_n;
        end
    end

    assign en_eff = shown_en & ~(blink_mask & {4{~phase_n}});
`else
    assign en_eff = shown_en;
`endif

    // Pins follow the next state so they switch on the same edge as the FSM
    always_comb begin
        an_n  = 4'hF;
        seg_n = 7'h7F;
        dp_n  = 1'b1;
        if (state_n == S_ON && en_eff[idx_n]) begin
            an_n          = ~(4'b0001 << idx_n);
            {dp_n, seg_n} = dec_digits[idx_n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an          <= 4'hF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_n;
            seg         <= seg_n;
            dp          <= dp_n;
            frame_start <= ~run | wrap;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb/tb_sevenseg_scan_ctrl.sv - directed self-checking bench for sevenseg_scan_ctrl
module tb_sevenseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [15:0] upd_value = 16'h0;
    logic [3:0]  upd_dp = 4'h0;
    logic [3:0]  upd_en = 4'h0;
    logic [15:0] dec_value;
    logic [3:0]  dec_dp;
    logic [7:0]  dec_digits [0:3];
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;
`ifdef SEVENSEG_BLINK_EN
    logic [3:0]  blink_mask = 4'b0001;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;

    sevenseg_scan_ctrl #(
        .TICKS_PER_DIGIT(4),
        .BLANK_TICKS(2)
`ifdef SEVENSEG_BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef SEVENSEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .upd_valid(upd_valid),
        .upd_ready(upd_ready),
        .upd_value(upd_value),
        .upd_dp(upd_dp),
        .upd_en(upd_en),
        .dec_value(dec_value),
        .dec_dp(dec_dp),
        .dec_digits(dec_digits),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dec_digits[i] = {~dec_dp[i], hex7(dec_value[4*i +: 4])};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic to(input int n);
        while (cyc < t0 + n) @(negedge clk);
    endtask

    task automatic offer(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        upd_value = v;
        upd_dp    = d;
        upd_en    = e;
        upd_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with a handshake offered that must be ignored
        @(negedge clk);
        offer(16'hFFFF, 4'hF, 4'hF);
        @(negedge clk);
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_fs", 32'(frame_start), 32'h0);
        check("rst_ready", 32'(upd_ready), 32'h1);
        upd_valid = 1'b0;
        @(negedge clk);
        check("rst_decval", 32'(dec_value), 32'h0);
        check("rst_decdp", 32'(dec_dp), 32'h0);
        rst = 1'b0;
        t0 = cyc;

        // Idle frames: dark, frame_start at 1 and 25
        for (int c = 1; c <= 48; c++) begin
            to(c);
            check("t1_an", 32'(an), 32'hF);
            check("t1_fs", 32'(frame_start), (c == 1 || c == 25) ? 32'd1 : 32'd0);
        end
        check("t1_seg", 32'(seg), 32'h7F);
        check("t1_ready", 32'(upd_ready), 32'h1);

        // First update 1234
        offer(16'h1234, 4'b0001, 4'hF);
        to(49);
        check("t2_ready_low", 32'(upd_ready), 32'h0);
        upd_valid = 1'b0;
        to(72);
        check("t2_dark_before", 32'(an), 32'hF);
        to(73);
        check("t2_decval", 32'(dec_value), 32'h1234);
        check("t2_ready_back", 32'(upd_ready), 32'h1);
        to(74);
        check("t2_blank_an", 32'(an), 32'hF);
        for (int c = 75; c <= 78; c++) begin
            to(c);
            check("t2_d0_an", 32'(an), 32'b1110);
            check("t2_d0_seg", 32'(seg), 32'b0011001);
            check("t2_d0_dp", 32'(dp), 32'h0);
        end
        to(79);
        check("t2_d0_end", 32'(an), 32'hF);
        to(93);
        check("t2_d3_an", 32'(an), 32'b0111);
        check("t2_d3_seg", 32'(seg), 32'b1111001);
        check("t2_d3_dp", 32'(dp), 32'h1);

        // Back-to-back updates: ABCD held while 5678 is pending
        to(97);
        offer(16'h5678, 4'h0, 4'hF);
        to(98);
        check("t3_ready_full", 32'(upd_ready), 32'h0);
        offer(16'hABCD, 4'h0, 4'hF);
        to(120);
        check("t3_stall", 32'(upd_ready), 32'h0);
        to(121);
        check("t3_commit_ready", 32'(upd_ready), 32'h1);
        check("t3_decval_5678", 32'(dec_value), 32'h5678);
        to(122);
        check("t3_accept", 32'(upd_ready), 32'h0);
        upd_valid = 1'b0;
        to(123);
        check("t3_8_an", 32'(an), 32'b1110);
        check("t3_8_seg", 32'(seg), 32'h00);
        to(145);
        check("t3_decval_abcd", 32'(dec_value), 32'hABCD);
        to(147);
        check("t3_d0_an", 32'(an), 32'b1110);
        check("t3_d0_seg", 32'(seg), 32'h21);
        check("t3_d0_dp", 32'(dp), 32'h1);
        to(153);
        check("t3_d1_an", 32'(an), 32'b1101);
        check("t3_d1_seg", 32'(seg), 32'h46);
        to(159);
        check("t3_d2_an", 32'(an), 32'b1011);
        check("t3_d2_seg", 32'(seg), 32'h03);
        to(165);
        check("t3_d3_an", 32'(an), 32'b0111);
        check("t3_d3_seg", 32'(seg), 32'h08);

        // Digit 3 disabled
        to(169);
        offer(16'hABCD, 4'h0, 4'b0111);
        to(170);
        upd_valid = 1'b0;
        for (int c = 193; c <= 216; c++) begin
            to(c);
            check("t4_an3_off", 32'(an[3]), 32'h1);
            if (c == 216) check("t4_fs_216", 32'(frame_start), 32'h0);
        end
        to(195);
        to(217);
        check("t4_fs_217", 32'(frame_start), 32'h1);

        // Reset in the middle of an ON phase with an update pending
        offer(16'h9999, 4'hF, 4'hF);
        to(218);
        check("t5_pend_full", 32'(upd_ready), 32'h0);
        upd_valid = 1'b0;
        to(220);
        check("t5_on_an", 32'(an), 32'b1110);
        check("t5_on_seg", 32'(seg), 32'h21);
        rst = 1'b1;
        #1;
        check("t5_async_an", 32'(an), 32'hF);
        check("t5_async_seg", 32'(seg), 32'h7F);
        check("t5_async_ready", 32'(upd_ready), 32'h1);
        check("t5_async_decval", 32'(dec_value), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        for (int c = 1; c <= 26; c++) begin
            to(c);
            check("t5_dark", 32'(an), 32'hF);
            if (c == 1 || c == 25) check("t5_fs", 32'(frame_start), 32'h1);
        end
        check("t5_no_commit", 32'(dec_value), 32'h0);
        check("t5_ready", 32'(upd_ready), 32'h1);

`ifdef SEVENSEG_BLINK_EN
        // Blink: digit 0 visible only in frames 4-5 of 2..6
        offer(16'h1234, 4'h0, 4'hF);
        to(27);
        upd_valid = 1'b0;
        for (int k = 2; k <= 6; k++) begin
            to(3 + 24 * k);
            check("t6_d0_an", 32'(an), (k == 4 || k == 5) ? 32'b1110 : 32'hF);
            to(9 + 24 * k);
            check("t6_d1_an", 32'(an), 32'b1101);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
